if_stage: RTL and testbench

// - Fetch stage directly upstream of id_stage: owns the PC register and drives synchronous-read BIOS/IMEM addresses.
// - ID sees the addressed instruction one cycle later, alongside id_pc.
// - Next PC comes from EX redirect, ID target, hold, or pc+4. Memory is addressed with next_pc, so an ID redirect costs no bubble.

---
 rtl/if_stage_if.sv | 40 ++++
 rtl/if_stage.sv | 90 +++++++++
 tb/tb_if_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage control/address bundle; IF_FETCH_CNT_EN adds fetch/redirect counters
interface if_stage_if #(
  parameter int BIOS_AW = 12,
  parameter int IMEM_AW = 14
);
  logic               ex_flush;
  logic [31:0]        ex_redirect_pc;
  logic [31:0]        id_target;
  logic               id_target_taken;
  logic               id_stall;
  logic               ex_stall;
  logic [BIOS_AW-1:0] bios_addr;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        id_pc;
  logic               id_bubble;
`ifdef IF_FETCH_CNT_EN
  logic [31:0]        fetch_cnt;
  logic [31:0]        redirect_cnt;

  modport master (
    input  ex_flush, ex_redirect_pc, id_target, id_target_taken, id_stall, ex_stall,
    output bios_addr, imem_addr, id_pc, id_bubble, fetch_cnt, redirect_cnt
  );

  modport slave (
    output ex_flush, ex_redirect_pc, id_target, id_target_taken, id_stall, ex_stall,
    input  bios_addr, imem_addr, id_pc, id_bubble, fetch_cnt, redirect_cnt
  );
`else
  modport master (
    input  ex_flush, ex_redirect_pc, id_target, id_target_taken, id_stall, ex_stall,
    output bios_addr, imem_addr, id_pc, id_bubble
  );

  modport slave (
    output ex_flush, ex_redirect_pc, id_target, id_target_taken, id_stall, ex_stall,
    input  bios_addr, imem_addr, id_pc, id_bubble
  );
`endif
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, next-PC select, boot FSM; IF_FETCH_CNT_EN adds counters
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_BOOT  = 2'd1,
    ST_RUN   = 2'd2
  } fsm_t;

  fsm_t        fsm_q;
  fsm_t        fsm_next;
  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        stall;
  logic        run;

  assign stall = bus.id_stall | bus.ex_stall;
  assign run   = (fsm_q == ST_RUN);

  // Boot sequencing: one RESET cycle, one BOOT cycle to let the RESET_PC read land, then RUN.
  always_comb begin
    fsm_next = fsm_q;
    case (fsm_q)
      ST_RESET: fsm_next = ST_BOOT;
      ST_BOOT:  fsm_next = ST_RUN;
      ST_RUN:   fsm_next = ST_RUN;
      default:  fsm_next = ST_RESET;
    endcase
  end

  // Next-PC select; memories are addressed with this so an ID redirect costs no bubble.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (!run)
      next_pc = RESET_PC;
    else if (bus.ex_flush)
      next_pc = bus.ex_redirect_pc;
    else if (stall)
      next_pc = pc_q;
    else if (bus.id_target_taken)
      next_pc = bus.id_target;
  end

  // State and PC registers; PC only follows next_pc once running (a stall is just a reload of pc_q).
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_q <= ST_RESET;
      pc_q  <= RESET_PC;
    end else begin
      fsm_q <= fsm_next;
      if (run)
        pc_q <= next_pc;
    end
  end

  assign bus.bios_addr = next_pc[BIOS_AW+1:2];
  assign bus.imem_addr = next_pc[IMEM_AW+1:2];
  assign bus.id_pc     = pc_q;
  assign bus.id_bubble = !run;

`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] redirect_cnt_q;

  // Activity counters: free fetches, and redirects actually taken (flush, or unstalled ID target).
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q    <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else if (run) begin
      if (!stall && !bus.ex_flush)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (bus.ex_flush || (bus.id_target_taken && !stall))
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt    = fetch_cnt_q;
  assign bus.redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  bit   run_m;
  logic [31:0] exp_fetch;
  logic [31:0] exp_redir;

  if_stage_if #(.BIOS_AW(12), .IMEM_AW(14)) bus ();

  if_stage #(.RESET_PC(32'h4000_0000), .BIOS_AW(12), .IMEM_AW(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, tracking expected counter values, then settle past the edge.
  task automatic step();
    if (!rst) begin
      exp_fetch = 32'd0;
      exp_redir = 32'd0;
    end else if (run_m) begin
      if (!bus.ex_flush && !bus.id_stall && !bus.ex_stall)
        exp_fetch = exp_fetch + 32'd1;
      if (bus.ex_flush || (bus.id_target_taken && !bus.id_stall && !bus.ex_stall))
        exp_redir = exp_redir + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush_to(input logic [31:0] pc);
    bus.ex_flush       = 1'b1;
    bus.ex_redirect_pc = pc;
    step();
    bus.ex_flush       = 1'b0;
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    run_m = 1'b0;
    exp_fetch = 32'd0;
    exp_redir = 32'd0;
    rst = 1'b0;
    bus.ex_flush = 1'b0;
    bus.ex_redirect_pc = 32'd0;
    bus.id_target = 32'd0;
    bus.id_target_taken = 1'b0;
    bus.id_stall = 1'b0;
    bus.ex_stall = 1'b0;
    #1;
    step();
    step();
    chk("rst_bubble", {31'd0, bus.id_bubble}, 32'd1);
    chk("rst_id_pc", bus.id_pc, 32'h4000_0000);
    chk("rst_imem", {18'd0, bus.imem_addr}, 32'd0);
    chk("rst_bios", {20'd0, bus.bios_addr}, 32'd0);

    // Reset release: two cycles of RESET_PC addresses, then running.
    rst = 1'b1;
    #1;
    chk("rel0_bubble", {31'd0, bus.id_bubble}, 32'd1);
    step();
    chk("boot_bubble", {31'd0, bus.id_bubble}, 32'd1);
    chk("boot_imem", {18'd0, bus.imem_addr}, 32'd0);
    step();
    run_m = 1'b1;
    chk("run_bubble", {31'd0, bus.id_bubble}, 32'd0);
    chk("run_id_pc", bus.id_pc, 32'h4000_0000);
    chk("run_imem", {18'd0, bus.imem_addr}, 32'd1);
    step();
    chk("run2_id_pc", bus.id_pc, 32'h4000_0004);

    // Sequential fetch from 0x1000_0000.
    bus.ex_flush = 1'b1;
    bus.ex_redirect_pc = 32'h1000_0000;
    #1;
    chk("flush_addr", {18'd0, bus.imem_addr}, 32'd0);
    step();
    bus.ex_flush = 1'b0;
    #1;
    chk("seq0_id_pc", bus.id_pc, 32'h1000_0000);
    step();
    chk("seq1_id_pc", bus.id_pc, 32'h1000_0004);
    chk("seq1_imem", {18'd0, bus.imem_addr}, 32'd2);
    step();
    chk("seq2_id_pc", bus.id_pc, 32'h1000_0008);
    chk("seq2_imem", {18'd0, bus.imem_addr}, 32'd3);
    step();
    chk("seq3_id_pc", bus.id_pc, 32'h1000_000C);
    chk("seq3_imem", {18'd0, bus.imem_addr}, 32'd4);
    step();
    chk("seq4_id_pc", bus.id_pc, 32'h1000_0010);

    // ID jump: ignored under id_stall, taken without it.
    bus.id_target = 32'h1000_0100;
    bus.id_target_taken = 1'b1;
    bus.id_stall = 1'b1;
    step();
    chk("jmp_stall_id_pc", bus.id_pc, 32'h1000_0010);
    bus.id_stall = 1'b0;
    #1;
    chk("jmp_imem", {18'd0, bus.imem_addr}, 32'h40);
    step();
    chk("jmp_id_pc", bus.id_pc, 32'h1000_0100);
    chk("jmp_bubble", {31'd0, bus.id_bubble}, 32'd0);
    bus.id_target_taken = 1'b0;

    // EX stall hold at 0x1000_0020.
    flush_to(32'h1000_0020);
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_id_pc", bus.id_pc, 32'h1000_0020);
      chk("stall_imem", {18'd0, bus.imem_addr}, 32'h0008);
    end
    bus.ex_stall = 1'b0;
    step();
    chk("unstall_id_pc", bus.id_pc, 32'h1000_0024);

    // Flush beats id_stall and id_target_taken; then flush with ex_stall.
    bus.ex_flush = 1'b1;
    bus.ex_redirect_pc = 32'h1000_0200;
    bus.id_stall = 1'b1;
    bus.id_target_taken = 1'b1;
    step();
    chk("flushprio_id_pc", bus.id_pc, 32'h1000_0200);
    bus.id_stall = 1'b0;
    bus.id_target_taken = 1'b0;
    bus.ex_stall = 1'b1;
    bus.ex_redirect_pc = 32'h1000_0300;
    step();
    chk("flush_exstall_id_pc", bus.id_pc, 32'h1000_0300);
    bus.ex_stall = 1'b0;
    bus.ex_flush = 1'b0;
    #1;

    // Wrap at the top of the address space.
    flush_to(32'hFFFF_FFFC);
    chk("wrap_pre_id_pc", bus.id_pc, 32'hFFFF_FFFC);
    chk("wrap_imem", {18'd0, bus.imem_addr}, 32'd0);
    step();
    chk("wrap_id_pc", bus.id_pc, 32'h0000_0000);
`ifdef IF_FETCH_CNT_EN
    chk("fetch_cnt", bus.fetch_cnt, exp_fetch);
    chk("redirect_cnt", bus.redirect_cnt, exp_redir);
`endif

    // Mid-run reset during a flush wins and drops the redirect.
    bus.ex_flush = 1'b1;
    bus.ex_redirect_pc = 32'h1234_5678;
    rst = 1'b0;
    step();
    run_m = 1'b0;
    chk("mrst_id_pc", bus.id_pc, 32'h4000_0000);
    chk("mrst_bubble", {31'd0, bus.id_bubble}, 32'd1);
    chk("mrst_imem", {18'd0, bus.imem_addr}, 32'd0);
`ifdef IF_FETCH_CNT_EN
    chk("mrst_fetch_cnt", bus.fetch_cnt, 32'd0);
    chk("mrst_redirect_cnt", bus.redirect_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
